// File: rtl/parking_lot_controller.sv
// Entry/exit sequencer for an 8-space lot: owns the occupancy map, arbitrates
// the shared barrier and holds gate_open for GATE_CYCLES cycles per served car.
module parking_lot_controller #(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic [2:0] exit_number,
    output logic       entry_ack,
    output logic [2:0] entry_number,
    output logic       entry_reject,
    output logic       exit_ack,
    output logic       exit_error,
    output logic [7:0] exit_onehot,
    output logic       gate_open,
    output logic [7:0] occupancy,
    output logic [3:0] free_count,
    output logic       full,
    output logic       empty
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_GATE = 2'd1,
        EXIT_GATE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] occ_q, occ_d;
    logic       entry_ack_q, entry_ack_d;
    logic [2:0] entry_number_q, entry_number_d;
    logic       entry_reject_q, entry_reject_d;
    logic       exit_ack_q, exit_ack_d;
    logic       exit_error_q, exit_error_d;
    logic [7:0] exit_onehot_q, exit_onehot_d;
    logic       gate_open_q, gate_open_d;

    logic [2:0] free_slot;
    logic       slot_found;
    logic [3:0] free_cnt;

    // Lowest-index free space and free-space count, both straight from the map.
    always_comb begin
        free_slot  = '0;
        slot_found = 1'b0;
        free_cnt   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!occ_q[i] && !slot_found) begin
                free_slot  = 3'(i);
                slot_found = 1'b1;
            end
            free_cnt = free_cnt + {3'b000, ~occ_q[i]};
        end
    end

    assign full       = (occ_q == '1);
    assign empty      = (occ_q == '0);
    assign free_count = free_cnt;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        occ_d          = occ_q;
        entry_ack_d    = 1'b0;
        entry_number_d = entry_number_q;
        entry_reject_d = 1'b0;
        exit_ack_d     = 1'b0;
        exit_error_d   = 1'b0;
        exit_onehot_d  = '0;
        gate_open_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Exit is checked first so a full lot can free a space before entry.
                if (exit_req) begin
                    if (occ_q[exit_number]) begin
                        occ_d[exit_number] = 1'b0;
                        exit_ack_d         = 1'b1;
                        exit_onehot_d      = 8'b0000_0001 << exit_number;
                        gate_open_d        = 1'b1;
                        cnt_d              = 4'(GATE_CYCLES - 1);
                        state_d            = EXIT_GATE;
                    end else begin
                        exit_error_d = 1'b1;
                    end
                end else if (entry_req) begin
                    if (!full) begin
                        occ_d[free_slot] = 1'b1;
                        entry_number_d   = free_slot;
                        entry_ack_d      = 1'b1;
                        gate_open_d      = 1'b1;
                        cnt_d            = 4'(GATE_CYCLES - 1);
                        state_d          = ENTRY_GATE;
                    end else begin
                        entry_reject_d = 1'b1;
                    end
                end
            end
            ENTRY_GATE, EXIT_GATE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d       = cnt_q - 4'd1;
                    gate_open_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            occ_q          <= '0;
            entry_ack_q    <= 1'b0;
            entry_number_q <= '0;
            entry_reject_q <= 1'b0;
            exit_ack_q     <= 1'b0;
            exit_error_q   <= 1'b0;
            exit_onehot_q  <= '0;
            gate_open_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            occ_q          <= occ_d;
            entry_ack_q    <= entry_ack_d;
            entry_number_q <= entry_number_d;
            entry_reject_q <= entry_reject_d;
            exit_ack_q     <= exit_ack_d;
            exit_error_q   <= exit_error_d;
            exit_onehot_q  <= exit_onehot_d;
            gate_open_q    <= gate_open_d;
        end
    end

    assign entry_ack    = entry_ack_q;
    assign entry_number = entry_number_q;
    assign entry_reject = entry_reject_q;
    assign exit_ack     = exit_ack_q;
    assign exit_error   = exit_error_q;
    assign exit_onehot  = exit_onehot_q;
    assign gate_open    = gate_open_q;
    assign occupancy    = occ_q;

endmodule

// File: tb/tb_parking_lot_controller.sv
// Scoreboard bench: stimulus pushes expected pulse events, a negedge monitor
// pops and compares them whenever the controller raises any pulse output.
module tb_parking_lot_controller;

    localparam int GATE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_number;
    logic       entry_ack;
    logic [2:0] entry_number;
    logic       entry_reject;
    logic       exit_ack;
    logic       exit_error;
    logic [7:0] exit_onehot;
    logic       gate_open;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;
    logic       empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] pulses;   // {entry_ack, entry_reject, exit_ack, exit_error}
        logic [2:0] num;
        logic [7:0] onehot;
        logic [7:0] occ;
    } exp_t;

    exp_t sb[$];

    parking_lot_controller #(.GATE_CYCLES(GATE)) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_req    (entry_req),
        .exit_req     (exit_req),
        .exit_number  (exit_number),
        .entry_ack    (entry_ack),
        .entry_number (entry_number),
        .entry_reject (entry_reject),
        .exit_ack     (exit_ack),
        .exit_error   (exit_error),
        .exit_onehot  (exit_onehot),
        .gate_open    (gate_open),
        .occupancy    (occupancy),
        .free_count   (free_count),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] p, input logic [2:0] n,
                            input logic [7:0] oh, input logic [7:0] occ);
        exp_t e;
        e.pulses = p;
        e.num    = n;
        e.onehot = oh;
        e.occ    = occ;
        sb.push_back(e);
    endtask

    // Monitor: any pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [3:0] p;
        exp_t       e;
        p = {entry_ack, entry_reject, exit_ack, exit_error};
        if (reset !== 1'b1) begin
            if (p != 4'b0000) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got pulses %b expected none (t=%0t)", p, $time);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", {28'd0, p}, {28'd0, e.pulses});
                    chk("pulse_onehot", {24'd0, exit_onehot}, {24'd0, e.onehot});
                    chk("pulse_occupancy", {24'd0, occupancy}, {24'd0, e.occ});
                    if (e.pulses == 4'b1000)
                        chk("entry_number", {29'd0, entry_number}, {29'd0, e.num});
                end
            end else begin
                chk("onehot_idle_zero", {24'd0, exit_onehot}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dwell();
        int n = 0;
        while (gate_open === 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("gate_dwell", n, GATE);
    endtask

    task automatic do_entry(input logic [2:0] num, input logic [7:0] occ);
        push_exp(4'b1000, num, 8'h00, occ);
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        chk("entry_gate_open", {31'd0, gate_open}, 32'd1);
        dwell();
    endtask

    task automatic do_exit(input logic [2:0] num, input logic [7:0] oh, input logic [7:0] occ);
        push_exp(4'b0010, 3'd0, oh, occ);
        exit_number = num;
        exit_req    = 1'b1;
        step();
        exit_req = 1'b0;
        chk("exit_gate_open", {31'd0, gate_open}, 32'd1);
        dwell();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        entry_req   = 1'b0;
        exit_req    = 1'b0;
        exit_number = 3'd0;
        step();

        // T1 reset
        do_reset(2);
        chk("rst_occupancy", {24'd0, occupancy}, 32'h00);
        chk("rst_free_count", {28'd0, free_count}, 32'd8);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_gate_open", {31'd0, gate_open}, 32'd0);
        chk("rst_pulses", {28'd0, entry_ack, entry_reject, exit_ack, exit_error}, 32'd0);
        chk("rst_entry_number", {29'd0, entry_number}, 32'd0);

        // T2 occupancy 0000_0101 then lowest free is space 1
        do_entry(3'd0, 8'h01);
        do_entry(3'd1, 8'h03);
        do_entry(3'd2, 8'h07);
        do_exit(3'd1, 8'h02, 8'h05);
        chk("t2_pre_occ", {24'd0, occupancy}, 32'h05);
        do_entry(3'd1, 8'h07);
        chk("t2_free_count", {28'd0, free_count}, 32'd5);

        // T3 fill from empty, then reject while held for two cycles
        do_reset(1);
        for (int i = 0; i < 8; i++)
            do_entry(3'(i), 8'((1 << (i + 1)) - 1));
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_free_count", {28'd0, free_count}, 32'd0);
        chk("t3_empty", {31'd0, empty}, 32'd0);
        push_exp(4'b0100, 3'd0, 8'h00, 8'hFF);
        push_exp(4'b0100, 3'd0, 8'h00, 8'hFF);
        entry_req = 1'b1;
        step();
        chk("t3_reject_gate", {31'd0, gate_open}, 32'd0);
        step();
        entry_req = 1'b0;
        chk("t3_reject_gate2", {31'd0, gate_open}, 32'd0);
        chk("t3_occ", {24'd0, occupancy}, 32'hFF);
        step();

        // T4 exit 5 ok, then exit 5 again is an error
        do_exit(3'd5, 8'h20, 8'hDF);
        chk("t4_free_count", {28'd0, free_count}, 32'd1);
        push_exp(4'b0001, 3'd0, 8'h00, 8'hDF);
        exit_number = 3'd5;
        exit_req    = 1'b1;
        step();
        exit_req = 1'b0;
        chk("t4_error_gate", {31'd0, gate_open}, 32'd0);
        chk("t4_error_occ", {24'd0, occupancy}, 32'hDF);
        step();

        // T5 simultaneous requests from a full lot: exit first, entry on return
        do_entry(3'd5, 8'hFF);
        push_exp(4'b0010, 3'd0, 8'h08, 8'hF7);
        push_exp(4'b1000, 3'd3, 8'h00, 8'hFF);
        exit_number = 3'd3;
        exit_req    = 1'b1;
        entry_req   = 1'b1;
        step();
        exit_req = 1'b0;
        chk("t5_exit_occ", {24'd0, occupancy}, 32'hF7);
        dwell();
        step();
        entry_req = 1'b0;
        chk("t5_entry_gate", {31'd0, gate_open}, 32'd1);
        dwell();
        chk("t5_final_occ", {24'd0, occupancy}, 32'hFF);

        // T6 reset on the 2nd gate cycle of an entry
        do_reset(1);
        push_exp(4'b1000, 3'd0, 8'h00, 8'h01);
        entry_req = 1'b1;
        step();
        entry_req = 1'b0;
        step();
        chk("t6_gate_before_rst", {31'd0, gate_open}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_gate_after_rst", {31'd0, gate_open}, 32'd0);
        chk("t6_occ_after_rst", {24'd0, occupancy}, 32'h00);
        chk("t6_free_after_rst", {28'd0, free_count}, 32'd8);
        do_entry(3'd0, 8'h01);

        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
